// File: rtl/vga_overlay_pkg.sv
// Shared constants and types for the VGA text overlay and its glyph ROM.
package vga_overlay_pkg;

   localparam int GLYPH_W = 5;
   localparam int GLYPH_H = 7;

   typedef enum logic [1:0] {
      MODE_STATIC       = 2'b00,
      MODE_BLINK        = 2'b01,
      MODE_SCROLL       = 2'b10,
      MODE_BLINK_SCROLL = 2'b11
   } mode_e;

   typedef logic [11:0] coord_t;

endpackage

// File: rtl/glyph_rom.sv
// 5x7 font lookup: ASCII code and glyph row in, five pixel bits out (MSB = leftmost column).
module glyph_rom
   import vga_overlay_pkg::*;
(
   input  logic [6:0]         code_i,
   input  logic [2:0]         row_i,
   output logic [GLYPH_W-1:0] bits_o
);

   logic [6:0]                 folded;
   logic [GLYPH_W*GLYPH_H-1:0] glyph;

   // Lowercase folds onto uppercase; anything without an entry (control codes) stays blank.
   always_comb begin
      folded = (code_i >= 7'h60) ? (code_i - 7'h20) : code_i;
      case (folded)
         7'h20: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
         7'h21: glyph = {5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h00, 5'h04};
         7'h22: glyph = {5'h0A, 5'h0A, 5'h0A, 5'h00, 5'h00, 5'h00, 5'h00};
         7'h23: glyph = {5'h0A, 5'h0A, 5'h1F, 5'h0A, 5'h1F, 5'h0A, 5'h0A};
         7'h24: glyph = {5'h04, 5'h0F, 5'h14, 5'h0E, 5'h05, 5'h1E, 5'h04};
         7'h25: glyph = {5'h18, 5'h19, 5'h02, 5'h04, 5'h08, 5'h13, 5'h03};
         7'h26: glyph = {5'h0C, 5'h12, 5'h14, 5'h08, 5'h15, 5'h12, 5'h0D};
         7'h27: glyph = {5'h0C, 5'h04, 5'h08, 5'h00, 5'h00, 5'h00, 5'h00};
         7'h28: glyph = {5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h04, 5'h02};
         7'h29: glyph = {5'h08, 5'h04, 5'h02, 5'h02, 5'h02, 5'h04, 5'h08};
         7'h2A: glyph = {5'h00, 5'h04, 5'h15, 5'h0E, 5'h15, 5'h04, 5'h00};
         7'h2B: glyph = {5'h00, 5'h04, 5'h04, 5'h1F, 5'h04, 5'h04, 5'h00};
         7'h2C: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h04, 5'h08};
         7'h2D: glyph = {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
         7'h2E: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C};
         7'h2F: glyph = {5'h00, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h00};
         7'h30: glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
         7'h31: glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         7'h32: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
         7'h33: glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
         7'h34: glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
         7'h35: glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
         7'h36: glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
         7'h37: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
         7'h38: glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
         7'h39: glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
         7'h3A: glyph = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
         7'h3B: glyph = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h04, 5'h08};
         7'h3C: glyph = {5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02};
         7'h3D: glyph = {5'h00, 5'h00, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00};
         7'h3E: glyph = {5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04, 5'h08};
         7'h3F: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h00, 5'h04};
         7'h40: glyph = {5'h0E, 5'h11, 5'h01, 5'h0D, 5'h15, 5'h15, 5'h0E};
         7'h41: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
         7'h42: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
         7'h43: glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
         7'h44: glyph = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
         7'h45: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
         7'h46: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
         7'h47: glyph = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
         7'h48: glyph = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
         7'h49: glyph = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
         7'h4A: glyph = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
         7'h4B: glyph = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
         7'h4C: glyph = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
         7'h4D: glyph = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
         7'h4E: glyph = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
         7'h4F: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
         7'h50: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
         7'h51: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
         7'h52: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
         7'h53: glyph = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
         7'h54: glyph = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
         7'h55: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
         7'h56: glyph = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
         7'h57: glyph = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
         7'h58: glyph = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
         7'h59: glyph = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
         7'h5A: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
         7'h5B: glyph = {5'h0E, 5'h08, 5'h08, 5'h08, 5'h08, 5'h08, 5'h0E};
         7'h5C: glyph = {5'h00, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h00};
         7'h5D: glyph = {5'h0E, 5'h02, 5'h02, 5'h02, 5'h02, 5'h02, 5'h0E};
         7'h5E: glyph = {5'h04, 5'h0A, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00};
         7'h5F: glyph = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F};
         default: glyph = '0;
      endcase
   end

   always_comb begin
      case (row_i)
         3'd0:    bits_o = glyph[34:30];
         3'd1:    bits_o = glyph[29:25];
         3'd2:    bits_o = glyph[24:20];
         3'd3:    bits_o = glyph[19:15];
         3'd4:    bits_o = glyph[14:10];
         3'd5:    bits_o = glyph[9:5];
         3'd6:    bits_o = glyph[4:0];
         default: bits_o = '0;
      endcase
   end

endmodule

// File: rtl/vga_text_overlay.sv
// Two-stage pixel pipeline drawing an N_CHARS string of scaled 5x7 glyphs, with a
// shadow buffer committed at frame start plus per-frame blink and scroll-with-wrap.
module vga_text_overlay
   import vga_overlay_pkg::*;
#(
   parameter  int N_CHARS      = 8,
   parameter  int SCALE        = 2,
   parameter  int START_X      = 85,
   parameter  int START_Y      = 95,
   parameter  int H_ACTIVE     = 1280,
   parameter  int BLINK_FRAMES = 30,
   parameter  int SCROLL_STEP  = 1,
   localparam int AW           = (N_CHARS > 1) ? $clog2(N_CHARS) : 1
)(
   input  logic          CLK_VGA,
   input  logic          RESET,
   input  logic [11:0]   VGA_horzCoord,
   input  logic [11:0]   VGA_vertCoord,
   input  logic          FRAME_START,
   input  logic          ENABLE,
   input  logic [1:0]    MODE,
   input  logic          WR_EN,
   input  logic [AW-1:0] WR_ADDR,
   input  logic [6:0]    WR_CHAR,
   output logic          WR_READY,
   output logic          NAME
);

   localparam int                PITCH   = 6 * SCALE;
   localparam int                SHIFT   = $clog2(SCALE);
   localparam int                BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic signed [12:0] BOX_W  = 13'(N_CHARS * PITCH);
   localparam logic signed [12:0] BOX_H  = 13'(GLYPH_H * SCALE);
   localparam logic [12:0]       PITCH_U = 13'(PITCH);
   localparam logic [AW:0]       N_U     = (AW + 1)'(N_CHARS);

   coord_t             horz, vert;
   mode_e              mode;
   logic               blinkMode, scrollMode, wrAccept;
   logic [6:0]         shadow_q [N_CHARS];
   logic [6:0]         display_q [N_CHARS];
   logic               dirty_q, ready_q;
   logic signed [12:0] originX_q, originX_d, stepX;
   logic signed [13:0] stepEnd;
   logic [BW-1:0]      blinkCnt_q, blinkCnt_d;
   logic               blinkPhase_q, blinkPhase_d;

   assign horz       = VGA_horzCoord;
   assign vert       = VGA_vertCoord;
   assign mode       = mode_e'(MODE);
   assign blinkMode  = (mode == MODE_BLINK) || (mode == MODE_BLINK_SCROLL);
   assign scrollMode = (mode == MODE_SCROLL) || (mode == MODE_BLINK_SCROLL);
   assign WR_READY   = ready_q && !FRAME_START;
   assign wrAccept   = WR_EN && WR_READY;

   // Per-frame updates; the wrap test uses one extra bit so origin + box width cannot overflow.
   always_comb begin
      stepX        = originX_q - 13'(SCROLL_STEP);
      stepEnd      = {stepX[12], stepX} + {BOX_W[12], BOX_W};
      originX_d    = originX_q;
      blinkCnt_d   = blinkCnt_q;
      blinkPhase_d = blinkPhase_q;
      if (FRAME_START) begin
         if (blinkCnt_q == BW'(BLINK_FRAMES - 1)) begin
            blinkCnt_d   = '0;
            blinkPhase_d = !blinkPhase_q;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
         if (scrollMode) begin
            originX_d = (stepEnd <= 0) ? 13'(H_ACTIVE) : stepX;
         end
      end
   end

   always_ff @(posedge CLK_VGA or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < N_CHARS; i++) begin
            shadow_q[i]  <= 7'h20;
            display_q[i] <= 7'h20;
         end
         dirty_q      <= 1'b0;
         ready_q      <= 1'b0;
         originX_q    <= 13'(START_X);
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
      end else begin
         ready_q      <= 1'b1;
         originX_q    <= originX_d;
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
         if (wrAccept) begin
            if ({1'b0, WR_ADDR} < N_U) begin
               shadow_q[WR_ADDR] <= WR_CHAR;
               dirty_q           <= 1'b1;
            end
         end else if (FRAME_START && dirty_q) begin
            for (int i = 0; i < N_CHARS; i++) begin
               display_q[i] <= shadow_q[i];
            end
            dirty_q <= 1'b0;
         end
      end
   end

   logic signed [12:0] relX, relY;
   logic               inBox_d, inBox_q, blank_q;
   logic [AW-1:0]      idx_d;
   logic [6:0]         code_d, code_q;
   logic [2:0]         row_d, row_q, col_d, col_q;
   logic [GLYPH_W-1:0] glyphBits;
   logic               pixBit, name_q;

   // Stage 1 address decode; out-of-box pixels read a space so idx never needs clamping.
   always_comb begin
      relX    = {1'b0, horz} - originX_q;
      relY    = {1'b0, vert} - 13'(START_Y);
      inBox_d = (relX >= 0) && (relX < BOX_W) && (relY >= 0) && (relY < BOX_H);
      idx_d   = AW'($unsigned(relX) / PITCH_U);
      col_d   = 3'(($unsigned(relX) % PITCH_U) >> SHIFT);
      row_d   = 3'($unsigned(relY) >> SHIFT);
      code_d  = inBox_d ? display_q[idx_d] : 7'h20;
   end

   glyph_rom uGlyphRom (
      .code_i (code_q),
      .row_i  (row_q),
      .bits_o (glyphBits)
   );

   always_comb begin
      pixBit = 1'b0;
      if (col_q < 3'(GLYPH_W)) begin
         pixBit = glyphBits[3'(GLYPH_W - 1) - col_q];
      end
   end

   always_ff @(posedge CLK_VGA or posedge RESET) begin
      if (RESET) begin
         inBox_q <= 1'b0;
         blank_q <= 1'b0;
         code_q  <= 7'h20;
         row_q   <= '0;
         col_q   <= '0;
         name_q  <= 1'b0;
      end else begin
         inBox_q <= inBox_d;
         blank_q <= blinkMode && blinkPhase_q;
         code_q  <= code_d;
         row_q   <= row_d;
         col_q   <= col_d;
         name_q  <= inBox_q && pixBit && ENABLE && !blank_q;
      end
   end

   assign NAME = name_q;

endmodule

// File: tb/tb_vga_text_overlay.sv
// Directed self-checking bench: one overlay with fast blink, one single-character
// instance with a large scroll step for exercising the wrap.
module tb_vga_text_overlay;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] horz, vert;
   logic        frameStart, enable;
   logic [1:0]  mode, mode2;
   logic        wrEn, wrEn2;
   logic [2:0]  wrAddr;
   logic [0:0]  wrAddr2;
   logic [6:0]  wrChar, wrChar2;
   logic        wrReady, wrReady2;
   logic        name, name2;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   vga_text_overlay #(.BLINK_FRAMES(2)) dut (
      .CLK_VGA       (clk),
      .RESET         (rst),
      .VGA_horzCoord (horz),
      .VGA_vertCoord (vert),
      .FRAME_START   (frameStart),
      .ENABLE        (enable),
      .MODE          (mode),
      .WR_EN         (wrEn),
      .WR_ADDR       (wrAddr),
      .WR_CHAR       (wrChar),
      .WR_READY      (wrReady),
      .NAME          (name)
   );

   vga_text_overlay #(.N_CHARS(1), .START_X(0), .SCROLL_STEP(6)) dutScroll (
      .CLK_VGA       (clk),
      .RESET         (rst),
      .VGA_horzCoord (horz),
      .VGA_vertCoord (vert),
      .FRAME_START   (frameStart),
      .ENABLE        (enable),
      .MODE          (mode2),
      .WR_EN         (wrEn2),
      .WR_ADDR       (wrAddr2),
      .WR_CHAR       (wrChar2),
      .WR_READY      (wrReady2),
      .NAME          (name2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int x, input int y);
      @(negedge clk);
      horz = 12'(x);
      vert = 12'(y);
   endtask

   // Drive a coordinate and wait out the two-cycle pipeline.
   task automatic probe(input int x, input int y);
      applyStimulus(x, y);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulseFrame();
      @(negedge clk);
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
   endtask

   task automatic writeChar(input int addr, input logic [6:0] ch);
      @(negedge clk);
      wrEn   = 1'b1;
      wrAddr = 3'(addr);
      wrChar = ch;
      @(negedge clk);
      wrEn   = 1'b0;
   endtask

   task automatic writeChar2(input int addr, input logic [6:0] ch);
      @(negedge clk);
      wrEn2   = 1'b1;
      wrAddr2 = 1'(addr);
      wrChar2 = ch;
      @(negedge clk);
      wrEn2   = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] simulation timed out");
   end

   initial begin
      int ones;
      logic blinkExp [5];
      blinkExp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; horz = '0; vert = '0; frameStart = 1'b0; enable = 1'b1;
      mode = 2'b00; mode2 = 2'b00;
      wrEn = 1'b0; wrAddr = '0; wrChar = '0;
      wrEn2 = 1'b0; wrAddr2 = '0; wrChar2 = '0;

      repeat (3) @(negedge clk);
      checkOutput("resetName", name, 1'b0);
      checkOutput("resetReady", wrReady, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("readyAfterReset", wrReady, 1'b1);

      ones = 0;
      for (int y = 95; y < 109; y++) begin
         for (int x = 85; x < 181; x++) begin
            applyStimulus(x, y);
            if (name) ones++;
         end
      end
      repeat (2) begin
         @(negedge clk);
         if (name) ones++;
      end
      checkOutput("sweepBlank", ones, 0);

      $display("[TB] static 'L' in slot 0");
      writeChar(0, 7'h4C);
      pulseFrame();
      probe(87, 95);
      applyStimulus(85, 95);
      @(negedge clk);
      checkOutput("latencyCycle1", name, 1'b0);
      @(negedge clk);
      checkOutput("latencyCycle2", name, 1'b1);
      probe(87, 95);
      checkOutput("lCol1Top", name, 1'b0);
      probe(87, 107);
      checkOutput("lBottomBar", name, 1'b1);
      probe(95, 95);
      checkOutput("gapColumn", name, 1'b0);
      applyStimulus(85, 95);
      applyStimulus(87, 95);
      applyStimulus(85, 95);
      checkOutput("stream0", name, 1'b1);
      @(negedge clk);
      checkOutput("stream1", name, 1'b0);
      @(negedge clk);
      checkOutput("stream2", name, 1'b1);
      enable = 1'b0;
      probe(85, 95);
      checkOutput("enableOff", name, 1'b0);
      enable = 1'b1;

      $display("[TB] shadow writes and commit");
      writeChar(0, 7'h58);
      writeChar(1, 7'h78);
      writeChar(2, 7'h0C);
      probe(89, 101);
      checkOutput("noCommitYet", name, 1'b0);
      pulseFrame();
      probe(89, 101);
      checkOutput("commitX", name, 1'b1);
      probe(101, 101);
      checkOutput("foldLowerX", name, 1'b1);
      probe(109, 95);
      checkOutput("controlBlank", name, 1'b0);

      @(negedge clk);
      frameStart = 1'b1;
      wrEn = 1'b1; wrAddr = 3'd0; wrChar = 7'h4C;
      #1;
      checkOutput("readyLowInFrame", wrReady, 1'b0);
      @(negedge clk);
      frameStart = 1'b0;
      wrEn = 1'b0;
      pulseFrame();
      probe(89, 101);
      checkOutput("frameWriteIgnored", name, 1'b1);

      $display("[TB] blink, two frames per half period");
      doReset();
      mode = 2'b01;
      writeChar(0, 7'h4C);
      repeat (4) pulseFrame();
      for (int k = 0; k < 5; k++) begin
         probe(85, 95);
         checkOutput($sformatf("blinkFrame%0d", k), name, blinkExp[k]);
         if (k == 2) begin
            mode = 2'b00;
            probe(85, 95);
            checkOutput("blinkIgnoredStatic", name, 1'b1);
            mode = 2'b01;
         end
         if (k < 4) pulseFrame();
      end
      mode = 2'b00;

      $display("[TB] scroll with wrap");
      writeChar2(0, 7'h4C);
      writeChar2(1, 7'h58);
      mode2 = 2'b10;
      pulseFrame();
      probe(0, 107);
      checkOutput("scrollStep", name2, 1'b1);
      probe(5, 107);
      checkOutput("scrollGap", name2, 1'b0);
      pulseFrame();
      probe(1280, 95);
      checkOutput("wrapInBox", name2, 1'b1);
      probe(0, 95);
      checkOutput("wrapLeftOff", name2, 1'b0);
      mode2 = 2'b00;
      pulseFrame();
      probe(1280, 95);
      checkOutput("scrollHeld", name2, 1'b1);

      $display("[TB] async reset mid-line");
      probe(85, 95);
      checkOutput("preResetOn", name, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncResetName", name, 1'b0);
      checkOutput("asyncResetReady", wrReady, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulseFrame();
      probe(85, 95);
      checkOutput("spacesAfterReset", name, 1'b0);
      writeChar2(0, 7'h4C);
      pulseFrame();
      probe(0, 95);
      checkOutput("originRestored", name2, 1'b1);
      probe(1280, 95);
      checkOutput("oldOriginGone", name2, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/vga_text_overlay.md
Name: vga_text_overlay

Overview:
- Parametrised, pipelined successor to the oscilloscope's fixed name-drawing logic.
- Renders an N_CHARS string of 5x7 font glyphs, pixel-scaled by SCALE, at a programmable screen origin as a 1-bit overlay for the VGA pixel mux.
- A shadow character buffer is written through a ready/enable handshake and committed tear-free at frame start.
- Adds per-frame blink and horizontal scroll-with-wrap modes.

Parameters:
- N_CHARS, 8, string length in characters (>=1).
- SCALE, 2, pixel replication factor; power of two, 1..8.
- START_X, 85, reset/static left edge of character 0, in pixels.
- START_Y, 95, top edge of text, in pixels.
- H_ACTIVE, 1280, visible width; scroll wrap re-entry x position.
- BLINK_FRAMES, 30, frames per blink half-period (>=1).
- SCROLL_STEP, 1, pixels moved left per frame in scroll modes.

Ports:
- CLK_VGA  in  1  pixel clock
- RESET  in  1  asynchronous, active-high reset
- VGA_horzCoord  in  12  current pixel x
- VGA_vertCoord  in  12  current pixel y
- FRAME_START  in  1  single-cycle pulse at the start of each frame
- ENABLE  in  1  overlay enable, applied at pipeline stage 2
- MODE  in  2  00 static, 01 blink, 10 scroll, 11 blink+scroll
- WR_EN  in  1  shadow buffer write request
- WR_ADDR  in  $clog2(N_CHARS) (min 1)  character slot
- WR_CHAR  in  7  ASCII code
- WR_READY  out  1  write accepted when WR_EN && WR_READY
- NAME  out  1  overlay pixel, 2-cycle latency from coordinates

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - NAME=0, WR_READY=0 while RESET is asserted, then 1.
  - Shadow and display buffers all 0x20 (space); dirty=0.
  - origin_x=START_X (13-bit signed); blink_cnt=0; blink_phase=0.
- Write path:
  - An accepted write updates shadow[WR_ADDR] and sets dirty.
  - WR_ADDR >= N_CHARS: accepted and ignored.
- Commit:
  - On FRAME_START with dirty=1, display<=shadow and dirty clears.
  - WR_READY=0 combinationally in any FRAME_START cycle, so WR_EN there is not accepted and has no effect.
  - Display buffer never changes mid-frame.
- Blink:
  - On FRAME_START, blink_cnt increments.
  - At BLINK_FRAMES-1, blink_cnt wraps to 0 and blink_phase toggles.
  - The counter runs in every mode. In modes 01/11, NAME is forced 0 while blink_phase=1.
- Scroll:
  - On FRAME_START in modes 10/11, origin_x -= SCROLL_STEP.
  - If the new origin_x + N_CHARS*PITCH <= 0, origin_x is set to H_ACTIVE instead (wrap).
  - In modes 00/01, origin_x is held; it does not snap back to START_X.
  - PITCH = 6*SCALE (5 glyph columns plus 1 gap column).
- Pixel pipeline, stage 1 (registered):
  - rel_x = horz - origin_x and rel_y = vert - START_Y, both signed 13-bit.
  - in_box = 0<=rel_x<N_CHARS*PITCH && 0<=rel_y<7*SCALE.
  - idx = rel_x/PITCH (constant divide); col = (rel_x mod PITCH)>>log2(SCALE); row = rel_y>>log2(SCALE).
  - Registers code=display[idx], row, col, in_box.
- Pixel pipeline, stage 2 (registered):
  - NAME <= in_box && col<5 && glyph_bit(code,row,col) && ENABLE && !(blink mode && blink_phase).
- Latency: exactly 2 CLK_VGA cycles from coordinates to NAME, with no bubbles. Coordinates are free-running and need no valid qualifier.
- Font:
  - Codes 0x20-0x5F have glyphs.
  - 0x60-0x7F fold to code-0x20 (uppercase).
  - 0x00-0x1F render blank.
- Simultaneous events: a commit, blink step and scroll step in the same FRAME_START all take effect together. Pixels in flight finish using the old values.

Decomposition:
- Shared package vga_overlay_pkg:
  - GLYPH_W=5, GLYPH_H=7.
  - Mode encodings MODE_STATIC/BLINK/SCROLL/BLINK_SCROLL.
  - 12-bit coordinate typedef.
- Sub-module glyph_rom: combinational code[6:0], row[2:0] -> 5-bit row bits (MSB = column 0), including the case-folding and blank rules.

Test Plan:
- Reset, then no writes: sweep the whole text box -> NAME=0 everywhere; WR_READY=1.
- Write slot 0='L' (0x4C), pulse FRAME_START, MODE=00, SCALE=2:
  - (85,95) -> NAME=1 exactly 2 cycles later.
  - (87,95) -> 0.
  - (87,107) -> 1 (bottom bar).
  - (95,95) -> 0 (gap column).
- Write 'X' to slot 0 with no FRAME_START -> old 'L' still renders. After FRAME_START -> 'X' renders. WR_EN during the FRAME_START cycle -> not accepted, dirty unchanged.
- MODE=01, BLINK_FRAMES=2 -> 'L' pixel at (85,95) reads 1,1,0,0,1 over 5 successive frames.
- MODE=10, N_CHARS=1, START_X=0, SCROLL_STEP=6:
  - origin_x steps 0 -> -6 -> 1280 (wrap).
  - After the second FRAME_START, pixel (1280,95) is in-box and (0,95) is off.
- Assert RESET mid-line while NAME=1 -> NAME=0 within the same cycle (async). Buffers read as spaces and origin_x=START_X after release.
